// File: rtl/sam_delay_pkg.sv
// Shared definitions for the sample-delay sweep-and-lock controller:
// FSM state encoding, datapath widths and the metric-width helper.
package sam_delay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_LOCKED  = 3'd4
    } state_e;

    localparam int SAM_W    = 32'sd18;
    localparam int DELAY_W  = 32'sd5;
    localparam int NUM_TAPS = 32'sd32;

    // Highest delay setting; reaching it in COMPARE ends the sweep.
    localparam logic [DELAY_W-1:0] LAST_TAP = DELAY_W'(NUM_TAPS - 32'sd1);

    // An accumulator of 2^log2_dwell 18-bit magnitudes needs this many bits.
    function automatic int metric_w(input int log2_dwell);
        return SAM_W + log2_dwell;
    endfunction

endpackage

// File: rtl/sym_metric_accum.sv
// Eye-opening metric accumulator: saturating absolute value of the
// post-delay sample, summed over the symbol instants of one dwell.
// clear has priority over en.
module sym_metric_accum
    import sam_delay_pkg::*;
#(
    parameter int ACC_W = 24
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [SAM_W-1:0] in,
    output logic        [ACC_W-1:0] acc
);

    // Two's-complement magnitude; the most negative code has no positive
    // counterpart, so it is clamped to the largest positive value.
    function automatic logic [SAM_W-1:0] sat_abs(input logic signed [SAM_W-1:0] x);
        logic [SAM_W-1:0] r;
        if (x == {1'b1, {(SAM_W-1){1'b0}}}) begin
            r = {1'b0, {(SAM_W-1){1'b1}}};
        end else if (x[SAM_W-1]) begin
            r = SAM_W'(-x);
        end else begin
            r = SAM_W'(x);
        end
        return r;
    endfunction

    logic [SAM_W-1:0] mag_s;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Magnitude of the current sample.
    always_comb begin
        mag_s = sat_abs(in);
    end

    // Next accumulator value: clear, add one magnitude, or hold.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(mag_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sam_delay_sweep_ctrl.sv
// Sweep-and-lock controller for the 32-tap receive sample-delay line.
// On start it steps delay 0..31, accumulates |in| over 2^LOG2_DWELL symbol
// instants at each setting, then locks delay to the setting with the
// largest metric (ties keep the lower delay).
// Optional feature macro: SAM_DELAY_SETTLE_EN -- when defined, SETTLE_SYMS
// symbol enables are discarded after every delay change before measuring.
module sam_delay_sweep_ctrl
    import sam_delay_pkg::*;
#(
    parameter int LOG2_DWELL    = 6,
    parameter int SETTLE_SYMS   = 4,
    parameter int DEFAULT_DELAY = 0
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sam_clk_en,
    input  logic                                sym_clk_en,
    input  logic                                start,
    input  logic signed [SAM_W-1:0]             in,
    output logic        [DELAY_W-1:0]           delay,
    output logic                                busy,
    output logic                                locked,
    output logic                                done,
    output logic        [metric_w(LOG2_DWELL)-1:0] best_metric
);

    localparam int MET_W = metric_w(LOG2_DWELL);
    localparam int CNT_W = LOG2_DWELL + 32'sd1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((32'd1 << LOG2_DWELL) - 32'd1);

`ifdef SAM_DELAY_SETTLE_EN
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SYMS - 32'sd1);
    localparam state_e     MEAS_ENTRY  = ST_SETTLE;
    logic [7:0] settle_cnt_q;
    logic [7:0] settle_cnt_d;
`else
    localparam state_e     MEAS_ENTRY  = ST_ACCUM;
    // Settle length has no effect when the settle phase is compiled out.
    logic unused_settle_syms_s;
    assign unused_settle_syms_s = (SETTLE_SYMS != 32'sd0);
`endif

    // Sample-rate enable is only a timing reference for neighbouring logic.
    logic unused_sam_clk_en_s;
    assign unused_sam_clk_en_s = sam_clk_en;

    state_e             state_q,    state_d;
    logic [DELAY_W-1:0] delay_q,    delay_d;
    logic [DELAY_W-1:0] best_idx_q, best_idx_d;
    logic [MET_W-1:0]   best_q,     best_d;
    logic               busy_q,     busy_d;
    logic               locked_q,   locked_d;
    logic               done_q,     done_d;
    logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic               acc_clear_s;
    logic               acc_en_s;
    logic [MET_W-1:0]   acc_s;

    sym_metric_accum #(
        .ACC_W (MET_W)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clear_s),
        .en    (acc_en_s),
        .in    (in),
        .acc   (acc_s)
    );

    // Next-state, sweep bookkeeping and accumulator control.
    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        busy_d      = busy_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
`ifdef SAM_DELAY_SETTLE_EN
        settle_cnt_d = settle_cnt_q;
`endif
        acc_clear_s = 1'b0;
        acc_en_s    = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                if (start) begin
                    delay_d     = '0;
                    best_d      = '0;
                    best_idx_d  = '0;
                    locked_d    = 1'b0;
                    busy_d      = 1'b1;
                    dwell_cnt_d = '0;
`ifdef SAM_DELAY_SETTLE_EN
                    settle_cnt_d = 8'd0;
`endif
                    acc_clear_s = 1'b1;
                    state_d     = MEAS_ENTRY;
                end else begin
                    state_d = state_q;
                end
            end

            ST_SETTLE: begin
`ifdef SAM_DELAY_SETTLE_EN
                if (sym_clk_en) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = 8'd0;
                        state_d      = ST_ACCUM;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q;
                end
`else
                // Unreachable without the settle phase; measure directly.
                state_d = ST_ACCUM;
`endif
            end

            ST_ACCUM: begin
                acc_en_s = sym_clk_en;
                if (sym_clk_en) begin
                    if (dwell_cnt_q == DWELL_LAST) begin
                        dwell_cnt_d = '0;
                        state_d     = ST_COMPARE;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q;
                end
            end

            ST_COMPARE: begin
                acc_clear_s = 1'b1;
                // Strict compare: a tie never displaces an earlier setting.
                if (acc_s > best_q) begin
                    best_d     = acc_s;
                    best_idx_d = delay_q;
                end else begin
                    best_d     = best_q;
                    best_idx_d = best_idx_q;
                end
                if (delay_q != LAST_TAP) begin
                    delay_d = delay_q + DELAY_W'(1);
                    state_d = MEAS_ENTRY;
                end else begin
                    delay_d  = best_idx_d;
                    busy_d   = 1'b0;
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_LOCKED;
                end
            end

            default: begin
                busy_d   = 1'b0;
                locked_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            delay_q     <= DELAY_W'(DEFAULT_DELAY);
            best_idx_q  <= '0;
            best_q      <= '0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            best_idx_q  <= best_idx_d;
            best_q      <= best_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

`ifdef SAM_DELAY_SETTLE_EN
    // Settle-phase symbol counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt_q <= 8'd0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
        end
    end
`endif

    assign delay       = delay_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign done        = done_q;
    assign best_metric = best_q;

endmodule
